dm_dump_reader: RTL and testbench

Post-run data-memory dump engine. Sits beside `top_level` on the data memory read port. When the core raises `done`, it walks a configured window of data memory and streams each byte out over a valid/ready byte interface, so result checking reads memory through hardware rather than through hierarchical pokes. It is the read-side counterpart to preloading the memory before the run.

---
 rtl/dm_dump_reader.sv | 154 +++++++++++++++
 tb/tb_dm_dump_reader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_dump_reader.sv
// Streams a window of data memory out as valid/ready bytes after the core finishes.
// Optional trailing XOR checksum beat: define DM_DUMP_CHECKSUM_EN.
`timescale 1ns/1ps
module dm_dump_reader #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int BASE  = 0,
  parameter int COUNT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          done,
  output logic [AW-1:0] dm_addr,
  output logic          dm_rd_en,
  input  logic [DW-1:0] dm_data,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          tx_last,
  output logic          busy,
  output logic          finished
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
`ifdef DM_DUMP_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  localparam logic [AW:0] LAST =
    (COUNT == 0) ? '0 : (AW+1)'(COUNT - 1);
  localparam logic [AW-1:0] BASE_A = AW'(BASE);

  state_t      state;
  state_t      next;
  logic        done_q;
  logic [AW:0] idx;
  logic        start;
  logic        hs;
  logic        at_last;

`ifdef DM_DUMP_CHECKSUM_EN
  logic [DW-1:0] csum;
`endif

  assign start   = done & ~done_q;
  assign hs      = tx_valid & tx_ready;
  assign at_last = (idx == LAST);

  always_comb begin
    next = state;
    case (state)
      IDLE:  if (start) next = (COUNT == 0) ? DONE : FETCH;
      FETCH: next = SEND;
      SEND: begin
        if (hs) begin
`ifdef DM_DUMP_CHECKSUM_EN
          next = at_last ? CSUM : FETCH;
`else
          next = at_last ? DONE : FETCH;
`endif
        end
      end
`ifdef DM_DUMP_CHECKSUM_EN
      CSUM:  if (hs) next = DONE;
`endif
      DONE:  if (!done) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    dm_rd_en = (state == FETCH);
    dm_addr  = '0;
    if (dm_rd_en) dm_addr = BASE_A + idx[AW-1:0];
    finished = (state == DONE);
    busy     = (state == FETCH) || (state == SEND);
`ifdef DM_DUMP_CHECKSUM_EN
    if (state == CSUM) busy = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= next;
      done_q <= done;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
`ifdef DM_DUMP_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx <= '0;
`ifdef DM_DUMP_CHECKSUM_EN
            csum <= '0;
`endif
          end
        end
        FETCH: begin
          tx_data  <= dm_data;
          tx_valid <= 1'b1;
`ifdef DM_DUMP_CHECKSUM_EN
          tx_last  <= 1'b0;
`else
          tx_last  <= at_last;
`endif
        end
        SEND: begin
          if (hs) begin
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            if (!at_last) idx <= idx + 1'b1;
`ifdef DM_DUMP_CHECKSUM_EN
            csum <= csum ^ tx_data;
            // the checksum beat follows the last data beat with no fetch gap
            if (at_last) begin
              tx_data  <= csum ^ tx_data;
              tx_valid <= 1'b1;
              tx_last  <= 1'b1;
            end
`endif
          end
        end
`ifdef DM_DUMP_CHECKSUM_EN
        CSUM: begin
          if (hs) begin
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_dump_reader.sv
// Bench for dm_dump_reader: three instances (plain, wrapping window, empty window).
// Expectations follow DM_DUMP_CHECKSUM_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_dm_dump_reader;

`ifdef DM_DUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       done_v   [3];
  logic [7:0] addr_v   [3];
  logic       rd_v     [3];
  logic [7:0] rdata_v  [3];
  logic [7:0] data_v   [3];
  logic       valid_v  [3];
  logic       ready_v  [3];
  logic       last_v   [3];
  logic       busy_v   [3];
  logic       fin_v    [3];
  logic [7:0] mem      [256];

  int total_cnt = 0;
  int pass_cnt  = 0;

  dm_dump_reader #(.AW(8), .DW(8), .BASE(0), .COUNT(4)) u_a (
    .clk(clk), .reset(reset), .done(done_v[0]),
    .dm_addr(addr_v[0]), .dm_rd_en(rd_v[0]), .dm_data(rdata_v[0]),
    .tx_data(data_v[0]), .tx_valid(valid_v[0]), .tx_ready(ready_v[0]),
    .tx_last(last_v[0]), .busy(busy_v[0]), .finished(fin_v[0])
  );

  dm_dump_reader #(.AW(8), .DW(8), .BASE(254), .COUNT(3)) u_b (
    .clk(clk), .reset(reset), .done(done_v[1]),
    .dm_addr(addr_v[1]), .dm_rd_en(rd_v[1]), .dm_data(rdata_v[1]),
    .tx_data(data_v[1]), .tx_valid(valid_v[1]), .tx_ready(ready_v[1]),
    .tx_last(last_v[1]), .busy(busy_v[1]), .finished(fin_v[1])
  );

  dm_dump_reader #(.AW(8), .DW(8), .BASE(0), .COUNT(0)) u_c (
    .clk(clk), .reset(reset), .done(done_v[2]),
    .dm_addr(addr_v[2]), .dm_rd_en(rd_v[2]), .dm_data(rdata_v[2]),
    .tx_data(data_v[2]), .tx_valid(valid_v[2]), .tx_ready(ready_v[2]),
    .tx_last(last_v[2]), .busy(busy_v[2]), .finished(fin_v[2])
  );

  always_comb begin
    for (int i = 0; i < 3; i++) rdata_v[i] = mem[addr_v[i]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]      k;
    logic [3:0]      words;
    logic [3:0]      beats;
    logic [3:0]      stall_beat;
    logic [4:0][7:0] data;
    logic [4:0]      last;
    logic [4:0][7:0] addr;
  } rec_t;

  rec_t tbl [2];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run(input int r);
    int k;
    int beat;
    int cyc;
    int acc;
    int rd;
    int stall;
    int gap;
    bit fresh;
    bit fin;
    logic [7:0] hd;
    logic hl;
    k = int'(tbl[r].k);
    beat = 0; cyc = 0; acc = 0; rd = 0; stall = 0;
    fresh = 1'b1; fin = 1'b0; hd = '0; hl = 1'b0;
    ready_v[k] = 1'b1;
    done_v[k]  = 1'b1;
    while (!fin && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (rd_v[k]) begin
        if (rd < int'(tbl[r].words))
          chk("dm_addr", int'(addr_v[k]), int'(tbl[r].addr[rd]));
        chk("rd_en_outside_fetch", int'(valid_v[k]), 0);
        rd++;
      end
      if (valid_v[k]) begin
        chk("busy", int'(busy_v[k]), 1);
        if (fresh) begin
          fresh = 1'b0;
          hd = data_v[k];
          hl = last_v[k];
          if (beat < int'(tbl[r].beats)) begin
            chk("tx_data", int'(data_v[k]), int'(tbl[r].data[beat]));
            chk("tx_last", int'(last_v[k]), int'(tbl[r].last[beat]));
          end
          gap = (CS && beat == int'(tbl[r].beats) - 1) ? 1 : 2;
          chk("beat_gap", cyc - acc, gap);
          if (beat == int'(tbl[r].stall_beat)) stall = 3;
        end else begin
          chk("stall_data", int'(data_v[k]), int'(hd));
          chk("stall_last", int'(last_v[k]), int'(hl));
        end
        if (stall > 0) begin
          ready_v[k] = 1'b0;
          stall--;
        end else begin
          ready_v[k] = 1'b1;
          beat++;
          fresh = 1'b1;
          acc = cyc;
        end
      end
      if (fin_v[k]) fin = 1'b1;
    end
    chk("finished_seen", int'(fin), 1);
    chk("beat_count", beat, int'(tbl[r].beats));
    chk("rd_en_count", rd, int'(tbl[r].words));
    repeat (2) begin
      @(negedge clk);
      chk("hold_finished", int'(fin_v[k]), 1);
      chk("hold_no_valid", int'(valid_v[k]), 0);
    end
    done_v[k] = 1'b0;
    @(negedge clk);
    chk("idle_finished", int'(fin_v[k]), 0);
    chk("idle_busy", int'(busy_v[k]), 0);
  endtask

  initial begin
    int nval;
    bit prev;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'hF0; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h00;
    mem[254] = 8'hAA; mem[255] = 8'h55;

    tbl[0] = '0;
    tbl[0].k = 2'd0; tbl[0].words = 4'd4; tbl[0].stall_beat = 4'hF;
    tbl[0].data[0] = 8'hF0; tbl[0].data[1] = 8'h01;
    tbl[0].data[2] = 8'h00; tbl[0].data[3] = 8'h00;
    tbl[0].addr[0] = 8'd0; tbl[0].addr[1] = 8'd1;
    tbl[0].addr[2] = 8'd2; tbl[0].addr[3] = 8'd3;
    tbl[1] = '0;
    tbl[1].k = 2'd1; tbl[1].words = 4'd3; tbl[1].stall_beat = 4'd0;
    tbl[1].data[0] = 8'hAA; tbl[1].data[1] = 8'h55; tbl[1].data[2] = 8'hF0;
    tbl[1].addr[0] = 8'd254; tbl[1].addr[1] = 8'd255; tbl[1].addr[2] = 8'd0;
    if (CS) begin
      tbl[0].beats = 4'd5; tbl[0].data[4] = 8'hF1; tbl[0].last[4] = 1'b1;
      tbl[1].beats = 4'd4; tbl[1].data[3] = 8'h0F; tbl[1].last[3] = 1'b1;
    end else begin
      tbl[0].beats = 4'd4; tbl[0].last[3] = 1'b1;
      tbl[1].beats = 4'd3; tbl[1].last[2] = 1'b1;
    end

    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      done_v[i] = 1'b0;
      ready_v[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    chk("rst_addr", int'(addr_v[0]), 0);
    chk("rst_rd_en", int'(rd_v[0]), 0);
    chk("rst_valid", int'(valid_v[0]), 0);
    chk("rst_busy", int'(busy_v[0]), 0);
    chk("rst_finished", int'(fin_v[0]), 0);
    reset = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 2; r++) run(r);

    // empty window: straight to DONE, no beats
    done_v[2] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("empty_valid", int'(valid_v[2]), 0);
      chk("empty_rd_en", int'(rd_v[2]), 0);
    end
    chk("empty_finished", int'(fin_v[2]), 1);
    repeat (3) @(negedge clk);
    chk("empty_hold", int'(fin_v[2]), 1);
    done_v[2] = 1'b0;
    @(negedge clk);
    chk("empty_idle", int'(fin_v[2]), 0);

    // reset in the middle of the second beat, then restart on release
    done_v[0] = 1'b1;
    ready_v[0] = 1'b0;
    nval = 0;
    prev = 1'b0;
    for (int c = 0; c < 40 && nval < 2; c++) begin
      @(negedge clk);
      if (valid_v[0] && !prev) nval++;
      prev = valid_v[0];
      ready_v[0] = (nval < 2);
    end
    chk("reset_wait", nval, 2);
    #2 reset = 1'b0;
    #1;
    chk("async_data", int'(data_v[0]), 0);
    chk("async_valid", int'(valid_v[0]), 0);
    chk("async_last", int'(last_v[0]), 0);
    chk("async_busy", int'(busy_v[0]), 0);
    @(negedge clk);
    reset = 1'b1;
    run(0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
